// File: rtl/pll_drp_sequencer.sv
// PLL DRP reconfiguration sequencer: holds the PLL in reset, read-modify-writes one of
// two register tables over DRP, then waits for LOCKED. Optional macro PLL_DRP_TIMEOUT_EN bounds every wait.
module pll_drp_sequencer #(
  parameter int unsigned               NUM_ENTRIES = 4,
  parameter logic [NUM_ENTRIES*39-1:0] TABLE0      = '0,
  parameter logic [NUM_ENTRIES*39-1:0] TABLE1      = '0,
  parameter int unsigned               TIMEOUT     = 1024
) (
  input  logic        DCLK,
  input  logic        RST,
  input  logic        SEN,
  input  logic        SADDR,
  output logic        SRDY,
  output logic        BUSY,
  output logic        ERR,
  output logic [6:0]  DADDR,
  output logic        DEN,
  output logic        DWE,
  output logic [15:0] DI,
  input  logic [15:0] DO,
  input  logic        DRDY,
  input  logic        LOCKED,
  output logic        PLL_RST
);

  typedef enum logic [3:0] {
    IDLE, ASSERT_RST, RD_ISSUE, RD_WAIT, MODIFY, WR_ISSUE, WR_WAIT, NEXT, WAIT_LOCK, DONE
  } state_t;

  // Tables padded to the full 3-bit index range so every index selects in bounds.
  localparam logic [8*39-1:0] TAB0     = (8*39)'(TABLE0);
  localparam logic [8*39-1:0] TAB1     = (8*39)'(TABLE1);
  localparam logic [2:0]      LAST_IDX = 3'(NUM_ENTRIES - 1);

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic        sel_q, sel_d;
  logic [15:0] rdata_q, rdata_d;
  logic [6:0]  daddr_q, daddr_d;
  logic        den_q, den_d;
  logic        dwe_q, dwe_d;
  logic [15:0] di_q, di_d;
  logic        pllrst_q, pllrst_d;
  logic        srdy_q, srdy_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;

  logic [8:0]  off;
  logic [38:0] entry;
  logic [6:0]  ent_addr;
  logic [15:0] ent_mask;
  logic [15:0] ent_data;
  logic        timeout_hit;

  always_comb begin
    off   = 9'(idx_q) * 9'd39;
    entry = sel_q ? TAB1[off +: 39] : TAB0[off +: 39];
  end
  assign {ent_addr, ent_mask, ent_data} = entry;

`ifdef PLL_DRP_TIMEOUT_EN
  logic [31:0] cnt_q, cnt_d;

  assign timeout_hit = (cnt_q == TIMEOUT - 1);

  // Clears on entry to a wait state, counts while staying in it.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d inside {RD_WAIT, WR_WAIT, WAIT_LOCK})
      cnt_d = (state_d == state_q) ? cnt_q + 32'd1 : '0;
  end

  always_ff @(posedge DCLK or posedge RST) begin
    if (RST) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign timeout_hit    = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    sel_d    = sel_q;
    rdata_d  = rdata_q;
    daddr_d  = daddr_q;
    den_d    = 1'b0;
    dwe_d    = 1'b0;
    di_d     = di_q;
    pllrst_d = pllrst_q;
    err_d    = err_q;
    busy_d   = !(state_q inside {IDLE, DONE});

    unique case (state_q)
      IDLE: if (SEN) begin
        sel_d   = SADDR;
        err_d   = 1'b0;
        idx_d   = '0;
        state_d = ASSERT_RST;
      end
      ASSERT_RST: begin
        pllrst_d = 1'b1;
        state_d  = RD_ISSUE;
      end
      RD_ISSUE: begin
        daddr_d = ent_addr;
        den_d   = 1'b1;
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (DRDY) begin
          rdata_d = DO;
          state_d = MODIFY;
        end else if (timeout_hit) begin
          err_d    = 1'b1;
          pllrst_d = 1'b0;
          state_d  = DONE;
        end
      end
      MODIFY: begin
        di_d    = (rdata_q & ent_mask) | (ent_data & ~ent_mask);
        state_d = WR_ISSUE;
      end
      WR_ISSUE: begin
        daddr_d = ent_addr;
        den_d   = 1'b1;
        dwe_d   = 1'b1;
        state_d = WR_WAIT;
      end
      WR_WAIT: begin
        if (DRDY) state_d = NEXT;
        else if (timeout_hit) begin
          err_d    = 1'b1;
          pllrst_d = 1'b0;
          state_d  = DONE;
        end
      end
      NEXT: begin
        if (idx_q == LAST_IDX) begin
          pllrst_d = 1'b0;
          state_d  = WAIT_LOCK;
        end else begin
          idx_d   = idx_q + 3'd1;
          state_d = RD_ISSUE;
        end
      end
      WAIT_LOCK: begin
        if (LOCKED) state_d = DONE;
        else if (timeout_hit) begin
          err_d    = 1'b1;
          pllrst_d = 1'b0;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    srdy_d = (state_d == DONE);
  end

  always_ff @(posedge DCLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      sel_q    <= 1'b0;
      rdata_q  <= '0;
      daddr_q  <= '0;
      den_q    <= 1'b0;
      dwe_q    <= 1'b0;
      di_q     <= '0;
      pllrst_q <= 1'b0;
      srdy_q   <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      sel_q    <= sel_d;
      rdata_q  <= rdata_d;
      daddr_q  <= daddr_d;
      den_q    <= den_d;
      dwe_q    <= dwe_d;
      di_q     <= di_d;
      pllrst_q <= pllrst_d;
      srdy_q   <= srdy_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
    end
  end

  assign DADDR   = daddr_q;
  assign DEN     = den_q;
  assign DWE     = dwe_q;
  assign DI      = di_q;
  assign PLL_RST = pllrst_q;
  assign SRDY    = srdy_q;
  assign BUSY    = busy_q;
  assign ERR     = err_q;

endmodule
